// File: rtl/reglk_resp_if.sv
// Request/response bus between the configuration bridge (master) and the
// register-lock responder (slave).
interface reglk_resp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/reglk_resp.sv
// Register-lock responder: sticky lock words guarding lock-protected data
// registers, served one transaction at a time over a request/response bus.
module reglk_resp #(
  parameter int NUM_REGS = 6,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  reglk_resp_if.slave                      bus,
  input  logic                             jtag_unlock_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  reglk_mem_o,
  output logic [NUM_REGS-1:0][DATA_W-1:0]  prot_reg_o,
  output logic                             lock_viol_o,
  output logic [7:0]                       viol_cnt_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                          state_q, state_d;
  logic                            we_p0;
  logic [ADDR_W-1:0]               addr_p0;
  logic [DATA_W-1:0]               wdata_p0;
  logic [NUM_REGS-1:0][DATA_W-1:0] reglk_q, reglk_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] prot_q, prot_d;
  logic                            err_c;
  logic                            hit_c;
  logic [DATA_W-1:0]               rdata_c;
  logic                            rsp_valid_p1;
  logic                            rsp_err_p1;
  logic [DATA_W-1:0]               rsp_rdata_p1;
  logic [7:0]                      viol_cnt_q;
  logic                            accept;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign bus.req_ready = (state_q == IDLE) && !rst_i;
  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_err   = rsp_err_p1;
  assign bus.rsp_rdata = rsp_rdata_p1;
  assign reglk_mem_o   = reglk_q;
  assign prot_reg_o    = prot_q;
  assign viol_cnt_o    = viol_cnt_q;
  assign lock_viol_o   = (state_q == EXEC) && err_c && !rst_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access decision; the _d values equal the current state whenever the access is rejected.
  always_comb begin
    reglk_d = reglk_q;
    prot_d  = prot_q;
    err_c   = 1'b0;
    hit_c   = 1'b0;
    rdata_c = '0;
    for (int j = 0; j < NUM_REGS; j++) begin
      if (addr_p0 == ADDR_W'(j)) begin
        hit_c = 1'b1;
        if (!we_p0)
          rdata_c = reglk_q[j];
        else if (jtag_unlock_i)
          reglk_d[j] = wdata_p0;
        else if ((reglk_q[j] & ~wdata_p0) != '0)
          err_c = 1'b1;
        else
          reglk_d[j] = reglk_q[j] | wdata_p0;
      end
      if (addr_p0 == ADDR_W'(8 + j)) begin
        hit_c = 1'b1;
        if (!we_p0)
          rdata_c = prot_q[j];
        else if (!reglk_q[j][0] || jtag_unlock_i)
          prot_d[j] = wdata_p0;
        else
          err_c = 1'b1;
      end
    end
    if (!hit_c) err_c = 1'b1;
  end

  // Stage p0: request capture
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_p0    <= bus.req_we;
      addr_p0  <= bus.req_addr;
      wdata_p0 <= bus.req_wdata;
    end
  end

  // Stage p1: commit and registered response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      reglk_q      <= {NUM_REGS{DATA_W'(1)}};
      prot_q       <= '0;
      rsp_valid_p1 <= 1'b0;
      rsp_err_p1   <= 1'b0;
      rsp_rdata_p1 <= '0;
      viol_cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == EXEC) begin
        reglk_q      <= reglk_d;
        prot_q       <= prot_d;
        rsp_valid_p1 <= 1'b1;
        rsp_err_p1   <= err_c;
        rsp_rdata_p1 <= err_c ? '0 : rdata_c;
        if (err_c) viol_cnt_q <= sat_inc8(viol_cnt_q);
      end else if (state_q == RESP && bus.rsp_ready) begin
        rsp_valid_p1 <= 1'b0;
        rsp_err_p1   <= 1'b0;
        rsp_rdata_p1 <= '0;
      end
    end
  end

endmodule

// File: tb/tb_reglk_resp.sv
// Bench for reglk_resp: directed vector table, hand-written corner sequences
// and randomized traffic against a behavioural model of the lock rules.
module tb_reglk_resp;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst_i;
  logic jtag_unlock_i;
  logic [N-1:0][31:0] reglk_mem_o;
  logic [N-1:0][31:0] prot_reg_o;
  logic lock_viol_o;
  logic [7:0] viol_cnt_o;

  reglk_resp_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  reglk_resp #(.NUM_REGS(N), .DATA_W(32), .ADDR_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .bus(bus), .jtag_unlock_i(jtag_unlock_i),
    .reglk_mem_o(reglk_mem_o), .prot_reg_o(prot_reg_o),
    .lock_viol_o(lock_viol_o), .viol_cnt_o(viol_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // behavioural model state
  logic [31:0] m_lk [N];
  logic [31:0] m_pr [N];
  int          m_cnt;

  // per-transaction observations
  logic viol_exec, viol_resp;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        jtag;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_lk[j] = 32'h1;
      m_pr[j] = 32'h0;
    end
    m_cnt = 0;
  endtask

  task automatic model(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                       input logic jtag, output logic err, output logic [31:0] rdata);
    int a;
    a = int'(addr);
    err = 1'b0;
    rdata = 32'h0;
    if (a < N) begin
      if (!we) rdata = m_lk[a];
      else if (jtag) m_lk[a] = wdata;
      else if ((m_lk[a] & ~wdata) != 0) err = 1'b1;
      else m_lk[a] = m_lk[a] | wdata;
    end else if (a >= 8 && a < 8 + N) begin
      if (!we) rdata = m_pr[a-8];
      else if (m_lk[a-8][0] == 1'b0 || jtag) m_pr[a-8] = wdata;
      else err = 1'b1;
    end else begin
      err = 1'b1;
    end
    if (err && m_cnt < 255) m_cnt++;
  endtask

  task automatic txn(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                     input logic jtag, input int stall,
                     output logic err, output logic [31:0] rdata);
    int waitc;
    logic rv_exec, rdy_exec, rv_resp;
    waitc = 0;
    err = 1'bx;
    rdata = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = 1'b0;
    jtag_unlock_i = jtag;
    while (!bus.req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    viol_exec = lock_viol_o;
    rv_exec = bus.rsp_valid;
    rdy_exec = bus.req_ready;
    @(negedge clk);
    jtag_unlock_i = ~jtag;
    rv_resp = bus.rsp_valid;
    err = bus.rsp_err;
    rdata = bus.rsp_rdata;
    viol_resp = lock_viol_o;
    check("rsp_valid_in_exec", 32'(rv_exec), 32'h0);
    check("rsp_valid_latency", 32'(rv_resp), 32'h1);
    check("req_ready_in_exec", 32'(rdy_exec), 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      check("stall_rsp_err", 32'(bus.rsp_err), 32'(err));
      check("stall_rsp_rdata", bus.rsp_rdata, rdata);
      check("stall_req_ready", 32'(bus.req_ready), 32'h0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
  endtask

  task automatic verify(input string tag, input logic err, input logic [31:0] rdata,
                        input logic exp_err, input logic [31:0] exp_rdata);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_viol_pulse"}, 32'(viol_exec), 32'(exp_err));
    check({tag, "_viol_after"}, 32'(viol_resp), 32'h0);
    for (int j = 0; j < N; j++) begin
      check({tag, "_reglk"}, reglk_mem_o[j], m_lk[j]);
      check({tag, "_prot"}, prot_reg_o[j], m_pr[j]);
    end
    check({tag, "_viol_cnt"}, 32'(viol_cnt_o), 32'(m_cnt));
  endtask

  logic        t_we, t_jtag, e_err, d_err;
  logic [3:0]  t_addr;
  logic [31:0] t_wdata, e_rd, d_rd;
  int          t_stall;

  initial begin
    tbl[0]  = '{1'b0, 4'd0,  32'h0,         1'b0, 1'b0, 32'h1};
    tbl[1]  = '{1'b0, 4'd8,  32'h0,         1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 4'd8,  32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0};
    tbl[3]  = '{1'b1, 4'd2,  32'h0,         1'b1, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 4'd10, 32'h1234,      1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 4'd10, 32'h0,         1'b0, 1'b0, 32'h1234};
    tbl[6]  = '{1'b1, 4'd2,  32'h0,         1'b0, 1'b0, 32'h0};
    tbl[7]  = '{1'b1, 4'd3,  32'h8000_0000, 1'b0, 1'b1, 32'h0};
    tbl[8]  = '{1'b1, 4'd3,  32'h8000_0001, 1'b0, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 4'd3,  32'h0,         1'b0, 1'b0, 32'h8000_0001};
    tbl[10] = '{1'b0, 4'd7,  32'h0,         1'b0, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 4'd15, 32'hFFFF,      1'b1, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 4'd14, 32'h0,         1'b0, 1'b1, 32'h0};

    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    jtag_unlock_i = 1'b0;
    viol_exec = 1'b0;
    viol_resp = 1'b0;
    rst_i = 1'b1;
    model_reset();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(bus.req_ready), 32'h0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_lock_viol", 32'(lock_viol_o), 32'h0);
    check("reset_viol_cnt", 32'(viol_cnt_o), 32'h0);
    for (int j = 0; j < N; j++) begin
      check("reset_reglk", reglk_mem_o[j], 32'h1);
      check("reset_prot", prot_reg_o[j], 32'h0);
    end
    rst_i = 1'b0;
    @(posedge clk);
    #1 check("post_reset_req_ready", 32'(bus.req_ready), 32'h1);

    // directed vector table
    for (int i = 0; i < 13; i++) begin
      model(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].jtag, e_err, e_rd);
      txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].jtag, 0, d_err, d_rd);
      verify($sformatf("vec%0d", i), d_err, d_rd, tbl[i].err, tbl[i].rdata);
    end
    check("vec_viol_cnt_total", 32'(viol_cnt_o), 32'd5);

    // long response stalls on unmapped addresses
    model(1'b0, 4'd7, 32'h0, 1'b0, e_err, e_rd);
    txn(1'b0, 4'd7, 32'h0, 1'b0, 5, d_err, d_rd);
    verify("stall7", d_err, d_rd, 1'b1, 32'h0);
    model(1'b1, 4'd15, 32'hA5A5_A5A5, 1'b0, e_err, e_rd);
    txn(1'b1, 4'd15, 32'hA5A5_A5A5, 1'b0, 5, d_err, d_rd);
    verify("stall15", d_err, d_rd, 1'b1, 32'h0);

    // reset during EXEC of an allowed write to protected register 2
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 4'd10;
    bus.req_wdata = 32'h5555_5555;
    jtag_unlock_i = 1'b0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rst_exec_no_viol", 32'(lock_viol_o), 32'h0);
    rst_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check("rst_exec_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_exec_req_ready", 32'(bus.req_ready), 32'h0);
    check("rst_exec_prot2", prot_reg_o[2], 32'h0);
    check("rst_exec_reglk2", reglk_mem_o[2], 32'h1);
    check("rst_exec_viol_cnt", 32'(viol_cnt_o), 32'h0);
    rst_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_exec_ready_after", 32'(bus.req_ready), 32'h1);
    check("rst_exec_rsp_after", 32'(bus.rsp_valid), 32'h0);
    check("rst_exec_prot2_after", prot_reg_o[2], 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      t_we = 1'($urandom_range(0, 1));
      t_addr = 4'($urandom_range(0, 15));
      t_jtag = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0: t_wdata = 32'h0;
        1: t_wdata = $urandom;
        2: t_wdata = m_lk[int'(t_addr) % N] | (32'h1 << $urandom_range(0, 31));
        default: t_wdata = 32'h1;
      endcase
      t_stall = $urandom_range(0, 2);
      model(t_we, t_addr, t_wdata, t_jtag, e_err, e_rd);
      txn(t_we, t_addr, t_wdata, t_jtag, t_stall, d_err, d_rd);
      verify("rand", d_err, d_rd, e_err, e_rd);
    end

    // drive the violation counter into saturation
    for (int i = 0; i < 300; i++) begin
      t_we = 1'($urandom_range(0, 1));
      model(t_we, 4'd6, 32'hFFFF_FFFF, 1'b0, e_err, e_rd);
      txn(t_we, 4'd6, 32'hFFFF_FFFF, 1'b0, 0, d_err, d_rd);
      verify("sat", d_err, d_rd, 1'b1, 32'h0);
    end
    check("viol_cnt_saturated", 32'(viol_cnt_o), 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reglk_resp.md
# reglk_resp

Register-lock responder: the consumer end of the lock-word and JTAG-unlock signals driven by the reset/lock logic. It owns six sticky lock words and six lock-protected data registers and serves them over a valid/ready request/response port. Every write to a protected register is checked against its lock word, and illegal accesses are reported. It sits between the configuration bus bridge and the peripherals whose configuration registers must be frozen after boot.

## Interface
- NUM_REGS, 6, number of lock words and protected registers; address map below holds for 6.
- DATA_W, 32, data width of lock words, protected registers and bus.
- ADDR_W, 4, request word-address width.
- clk_i  in  1  single clock; all state updates on posedge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid && ready.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  ADDR_W  word address.
- req_wdata_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid && ready.
- rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
- rsp_err_o  out  1  access rejected.
- jtag_unlock_i  in  1  debug unlock; sampled in EXEC.
- reglk_mem_o  out  NUM_REGS x DATA_W  current lock words.
- prot_reg_o  out  NUM_REGS x DATA_W  current protected registers.
- lock_viol_o  out  1  one-cycle pulse on every rejected access.
- viol_cnt_o  out  8  saturating count of rejected accesses.

## Operation
- Address map:
  - 0..5: lock word j.
  - 8..13: protected register j-8.
  - 6, 7, 14, 15: unmapped.
- Lock semantics: bit 0 of lock word j is the write lock for protected register j. Bits 31..1 are software-defined sticky flags.
- Lock-word write, jtag_unlock_i=1: full overwrite, no error.
- Lock-word write, jtag_unlock_i=0:
  - Rejected (no change, err=1) if it would clear any currently set bit, i.e. (old & ~wdata) != 0.
  - Otherwise new = old | wdata, err=0.
- Protected-register write:
  - Allowed if lock bit 0 = 0 or jtag_unlock_i = 1.
  - Otherwise rejected: no change, err=1.
- Reads: any mapped address, never an error, return the current value.
- Unmapped address, read or write: err=1, rdata=0, no state change.
- Every rejected access: lock_viol_o pulses for one cycle (the EXEC cycle); viol_cnt_o increments, saturating at 255.
- FSM states:
  - IDLE: req_ready_o=1. On accept, latch we/addr/wdata and go to EXEC.
  - EXEC: evaluate, commit the update at the end of this cycle, register the response, go to RESP.
  - RESP: rsp_valid_o=1 and response fields stable. On rsp_ready_i go to IDLE.
- Only one transaction is in flight; req_ready_o=0 in EXEC and RESP.

## Timing
- Reset values (the cycle after rst_i is sampled high):
  - State IDLE.
  - Every reglk_mem_o word = 32'h0000_0001 (locked).
  - Every prot_reg_o word = 0.
  - rsp_valid_o=0, rsp_err_o=0, rsp_rdata_o=0.
  - lock_viol_o=0, viol_cnt_o=0.
  - req_ready_o=0 while rst_i is high; 1 in the first cycle after reset deasserts.
- Latency:
  - Accept at edge N.
  - EXEC during cycle N+1; write visible on reglk_mem_o/prot_reg_o from edge N+2.
  - rsp_valid_o high from edge N+2.
  - With rsp_ready_i held high, req_ready_o is high again from edge N+3. Back-to-back throughput is one transaction per 3 cycles.
- rsp_valid_o stays high and all rsp fields hold until the handshake; stalls are unbounded.
- Read in EXEC returns the value before any same-transaction update (reads have no updates).
- jtag_unlock_i changes outside EXEC have no effect on an in-flight decision.
- rst_i high in any state aborts the transaction: no commit if in EXEC, response dropped, all registers return to reset values.
- viol_cnt_o at 255 plus another violation: stays 255; lock_viol_o still pulses.

## Test plan
- Reset then read addr 0 and addr 8 -> rdata 32'h1 / 32'h0, err=0, rsp_valid_o exactly 2 cycles after accept.
- Write 32'hDEAD_BEEF to addr 8 with jtag_unlock_i=0 -> err=1, prot_reg_o[0] stays 0, lock_viol_o one pulse, viol_cnt_o=1.
- Write 32'h0 to addr 2 with jtag_unlock_i=1 -> lock word 2 = 0. Then write 32'h1234 to addr 10 -> prot_reg_o[2]=32'h1234, err=0. Then write 32'h0 to addr 2 with jtag_unlock_i=0 -> only sticky OR applies (0|0), err=0.
- Lock word 3 = 32'h1, write 32'h8000_0000 with jtag_unlock_i=0 -> err=1, word unchanged. Write 32'h8000_0001 -> word = 32'h8000_0001, err=0.
- Access addr 7 and addr 15 -> err=1, rdata=0. Hold rsp_ready_i low 5 cycles -> response stable, req_ready_o=0 throughout.
- Assert rst_i during EXEC of an unlocked write -> no commit, rsp_valid_o=0, reset values restored. Also run 300 violations -> viol_cnt_o=255.
